// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial shift-register link (transmit and receive).
package serial_link_pkg;

   // Default word width of the link, shared with the transmitter.
   localparam int LINK_WIDTH = 3;

   // Receiver framing states.
   typedef enum logic {
      RX_IDLE  = 1'b0,
      RX_SHIFT = 1'b1
   } rx_state_t;

   // Width of a counter that must hold values 0..width inclusive.
   function automatic int bit_cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/sipo_stage.sv
// One bit of the receive shift register: loads d_i when en_i is high.
module sipo_stage (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic d_i,
   output logic q_o
);

   // Enabled flop with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_o <= 1'b0;
      end else if (en_i) begin
         q_o <= d_i;
      end
   end

endmodule

// File: rtl/serial_word_rx.sv
// Serial-to-parallel receiver: frames bits with a sync marker, shifts them
// into a per-bit register chain and hands completed words downstream over a
// valid/ready pair, flagging aborted frames and dropped words.
//
// Handshake: dout is offered while dout_valid is high and is held stable until
// the edge where dout_ready is also high; that edge consumes it. A word that
// completes while an unconsumed word is held and dout_ready is low is dropped
// and sets the sticky overrun flag.
module serial_word_rx
   import serial_link_pkg::*;
#(
   parameter int WIDTH = LINK_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ser_valid,
   input  logic             ser_data,
   input  logic             sync,
   output logic [0:WIDTH-1] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             frame_err,
   output logic             overrun,
   input  logic             ovr_clr
);

   localparam int CW = bit_cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

   rx_state_t        state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sr_q;
   logic [WIDTH-1:0] shift_d;
   logic             shift_en;
   logic             word_done;
   logic [0:WIDTH-1] dout_q, dout_d;
   logic             dout_valid_q, dout_valid_d;
   logic             frame_err_q, frame_err_d;
   logic             overrun_q, overrun_d;

   // Next shift-register contents: new bit enters stage 0, others move up.
   always_comb begin
      shift_d    = '0;
      shift_d[0] = ser_data;
      for (int i = 1; i < WIDTH; i++) begin
         shift_d[i] = sr_q[i-1];
      end
   end

   genvar g;
   generate
      for (g = 0; g < WIDTH; g++) begin : g_stage
         sipo_stage u_stage (
            .clk  (clk),
            .rst  (reset),
            .en_i (shift_en),
            .d_i  (shift_d[g]),
            .q_o  (sr_q[g])
         );
      end
   endgenerate

   // Framing FSM: decides when a bit is captured and when a word completes.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shift_en    = 1'b0;
      word_done   = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         RX_IDLE: begin
            if (ser_valid && sync) begin
               shift_en = 1'b1;
               if (CNT_FULL == CNT_ONE) begin
                  // Single-bit words complete on their own sync bit.
                  word_done = 1'b1;
               end else begin
                  cnt_d   = CNT_ONE;
                  state_d = RX_SHIFT;
               end
            end
         end
         RX_SHIFT: begin
            if (ser_valid) begin
               shift_en = 1'b1;
               if (sync) begin
                  // Early sync: restart the frame with this bit as bit 1.
                  frame_err_d = 1'b1;
                  cnt_d       = CNT_ONE;
               end else if (cnt_q + CNT_ONE == CNT_FULL) begin
                  word_done = 1'b1;
                  cnt_d     = '0;
                  state_d   = RX_IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         default: begin
            state_d = RX_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Output holding register, valid/ready handshake and overrun tracking.
   always_comb begin
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      overrun_d    = overrun_q;
      if (word_done && dout_valid_q && !dout_ready) begin
         overrun_d = 1'b1;
      end else if (ovr_clr) begin
         overrun_d = 1'b0;
      end
      if (word_done && (!dout_valid_q || dout_ready)) begin
         for (int i = 0; i < WIDTH; i++) begin
            dout_d[i] = shift_d[i];
         end
         dout_valid_d = 1'b1;
      end else if (dout_ready) begin
         dout_valid_d = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= RX_IDLE;
         cnt_q        <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;

endmodule
